// File: rtl/wei_sched_pkg.sv
// Shared constants and FSM state encoding for the weight scheduler.
package wei_sched_pkg;
   localparam int DATA_WIDTH   = 8;
   localparam int KERNEL_WIDTH = 3;
   localparam int KERNEL_SIZE  = KERNEL_WIDTH * KERNEL_WIDTH;
   localparam int POS_WIDTH    = $clog2(KERNEL_WIDTH);
   localparam int NNZ_WIDTH    = $clog2(KERNEL_SIZE + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FLAG  = 3'd1,
      LOAD  = 3'd2,
      ISSUE = 3'd3,
      DONE  = 3'd4
   } state_t;
endpackage

// File: rtl/wei_sched_popcnt.sv
// Population count of a W-bit vector.
module wei_sched_popcnt #(
   parameter int W  = 3,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  bits,
   output logic [CW-1:0] count
);
   always_comb begin
      count = '0;
      for (int i = 0; i < W; i++) count = count + CW'(bits[i]);
   end
endmodule

// File: rtl/wei_sched.sv
// Weight scheduler: captures a kernel nonzero mask, loads packed weights, issues them
// row-major with position tags. Build option WEI_SCHED_EMPTY_ROW_EN adds one marker per empty row.
//
// state | meaning
// IDLE  | waiting for start
// FLAG  | accepting the nonzero mask
// LOAD  | accepting nnz packed weights into the buffer
// ISSUE | presenting weights (and row markers) on the out channel
// DONE  | one-cycle completion pulse
module wei_sched #(
   parameter int DATA_WIDTH   = wei_sched_pkg::DATA_WIDTH,
   parameter int KERNEL_WIDTH = wei_sched_pkg::KERNEL_WIDTH
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          start,
   input  logic                                          flag_valid,
   output logic                                          flag_ready,
   input  logic [KERNEL_WIDTH*KERNEL_WIDTH-1:0]          flag_data,
   input  logic                                          wei_valid,
   output logic                                          wei_ready,
   input  logic [DATA_WIDTH-1:0]                         wei_data,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [DATA_WIDTH-1:0]                         out_data,
   output logic [$clog2(KERNEL_WIDTH)-1:0]               out_row,
   output logic [$clog2(KERNEL_WIDTH)-1:0]               out_col,
   output logic                                          out_row_last,
   output logic                                          out_last,
   output logic                                          busy,
   output logic                                          done,
   output logic [$clog2(KERNEL_WIDTH*KERNEL_WIDTH+1)-1:0] nnz
);
   import wei_sched_pkg::*;

   localparam int KS     = KERNEL_WIDTH * KERNEL_WIDTH;
   localparam int RC_W   = $clog2(KERNEL_WIDTH);
   localparam int NNZ_W  = $clog2(KS + 1);
   localparam int RCNT_W = $clog2(KERNEL_WIDTH + 1);
`ifdef WEI_SCHED_EMPTY_ROW_EN
   localparam bit EMPTY_ROW_EN = 1'b1;
`else
   localparam bit EMPTY_ROW_EN = 1'b0;
`endif

   state_t state, state_nxt;

   logic [KS-1:0]           mask_rem;
   logic [KERNEL_WIDTH-1:0] mark_rem;
   logic [NNZ_W-1:0]        nnz_q, wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0]   wbuf [KS];

   logic [RCNT_W-1:0]       row_cnt [KERNEL_WIDTH];
   logic [KERNEL_WIDTH-1:0] empty_rows;
   logic [NNZ_W-1:0]        pop_all;

   logic [KS-1:0] pend;
   int            cur_r, cur_c;
   logic          is_marker, row_last_i, last_i;
   logic          flag_hs, wei_hs, out_hs;

   for (genvar r = 0; r < KERNEL_WIDTH; r++) begin : g_row
      wei_sched_popcnt #(.W(KERNEL_WIDTH)) u_row_cnt (
         .bits  (flag_data[r*KERNEL_WIDTH +: KERNEL_WIDTH]),
         .count (row_cnt[r])
      );
      assign empty_rows[r] = (row_cnt[r] == '0);
   end

   wei_sched_popcnt #(.W(KS)) u_nnz_cnt (
      .bits  (flag_data),
      .count (pop_all)
   );

   assign flag_ready = (state == FLAG);
   assign wei_ready  = (state == LOAD) && (wr_ptr != nnz_q);
   assign out_valid  = (state == ISSUE);
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign nnz        = nnz_q;

   assign flag_hs = flag_valid && flag_ready;
   assign wei_hs  = wei_valid && wei_ready;
   assign out_hs  = out_valid && out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = FLAG;
         FLAG:  if (flag_hs) state_nxt = (pop_all != '0 || EMPTY_ROW_EN) ? LOAD : DONE;
         // nnz==0 only reaches LOAD when row markers are enabled
         LOAD:  if (wr_ptr == nnz_q || (wei_hs && (wr_ptr + NNZ_W'(1)) == nnz_q))
                   state_nxt = ISSUE;
         ISSUE: if (out_hs && last_i) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Pending elements: remaining mask bits plus a virtual col-0 bit per empty-row marker.
   always_comb begin
      pend = mask_rem;
      for (int r = 0; r < KERNEL_WIDTH; r++)
         pend[r*KERNEL_WIDTH] = pend[r*KERNEL_WIDTH] | mark_rem[r];
   end

   always_comb begin
      cur_r = 0;
      cur_c = 0;
      for (int r = KERNEL_WIDTH - 1; r >= 0; r--)
         for (int c = KERNEL_WIDTH - 1; c >= 0; c--)
            if (pend[r*KERNEL_WIDTH + c]) begin
               cur_r = r;
               cur_c = c;
            end
      row_last_i = 1'b1;
      for (int c = 0; c < KERNEL_WIDTH; c++)
         if (c > cur_c && pend[cur_r*KERNEL_WIDTH + c]) row_last_i = 1'b0;
      last_i    = ((pend & (pend - KS'(1))) == '0);
      is_marker = mark_rem[cur_r];
   end

   assign out_data     = (out_valid && !is_marker) ? wbuf[rd_ptr] : '0;
   assign out_row      = out_valid ? RC_W'(cur_r) : '0;
   assign out_col      = out_valid ? RC_W'(cur_c) : '0;
   assign out_row_last = out_valid && row_last_i;
   assign out_last     = out_valid && last_i;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_rem <= '0;
         mark_rem <= '0;
         nnz_q    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         for (int i = 0; i < KS; i++) wbuf[i] <= '0;
      end else begin
         if (flag_hs) begin
            mask_rem <= flag_data;
            mark_rem <= empty_rows & {KERNEL_WIDTH{EMPTY_ROW_EN}};
            nnz_q    <= pop_all;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
         end
         if (wei_hs) begin
            wbuf[wr_ptr] <= wei_data;
            wr_ptr       <= wr_ptr + NNZ_W'(1);
         end
         if (out_hs) begin
            if (is_marker) mark_rem[cur_r] <= 1'b0;
            else begin
               mask_rem[cur_r*KERNEL_WIDTH + cur_c] <= 1'b0;
               rd_ptr <= rd_ptr + NNZ_W'(1);
            end
         end
      end
   end
endmodule

// File: doc/wei_sched.md
WEI_SCHED -- requirements
Module: wei_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the width of one weight word.
REQ-002 SHALL have parameter KERNEL_WIDTH, default 3, meaning the kernel row/column length; KERNEL_SIZE = KERNEL_WIDTH*KERNEL_WIDTH.
REQ-003 SHALL have port clk input 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset input 1: asynchronous, active-high reset.
REQ-005 SHALL have port start input 1: begins one kernel load/issue pass.
REQ-006 SHALL have ports flag_valid input 1, flag_ready output 1 and flag_data input KERNEL_SIZE: the nonzero mask, bit r*KERNEL_WIDTH+c = position (r,c).
REQ-007 SHALL have ports wei_valid input 1, wei_ready output 1 and wei_data input DATA_WIDTH: packed nonzero weights in mask bit order.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1 and out_data output DATA_WIDTH: the issued weight.
REQ-009 SHALL have ports out_row output clog2(KERNEL_WIDTH), out_col output clog2(KERNEL_WIDTH), out_row_last output 1 and out_last output 1: the issued weight's position, last-in-row flag and last-in-kernel flag.
REQ-010 SHALL have ports busy output 1, done output 1 (one-cycle pulse) and nnz output clog2(KERNEL_SIZE+1): the popcount of the captured mask.

Function
REQ-011 SHALL implement FSM states IDLE, FLAG, LOAD, ISSUE and DONE.
REQ-012 FSM transitions SHALL be:
- IDLE->FLAG on start.
- FLAG->LOAD on a flag handshake with nnz>0.
- FLAG->DONE on a flag handshake with nnz==0.
- LOAD->ISSUE when the nnz-th weight handshakes.
- ISSUE->DONE on the out handshake with out_last=1.
- DONE->IDLE unconditionally.
REQ-013 flag_ready SHALL be 1 only in FLAG, and wei_ready SHALL be 1 only in LOAD.
REQ-014 A handshake SHALL occur on any cycle where valid and ready are both 1.
REQ-015 On a flag handshake the block SHALL capture the mask and nnz, and compute per-row counts with KERNEL_WIDTH-bit popcount arithmetic.
REQ-016 In LOAD the block SHALL write each accepted weight into a KERNEL_SIZE-entry buffer at the write pointer, then increment the pointer; writes beyond nnz are impossible because wei_ready drops.
REQ-017 out_valid SHALL assert in the first ISSUE cycle, so the first weight is presented 1 cycle after the last LOAD handshake.
REQ-018 Issue order SHALL be row-major: ascending row, then ascending column, over set mask bits only; buffer entries are read in order.
REQ-019 Output payload SHALL be held stable while out_valid=1 and out_ready=0, and SHALL advance one element per handshake with no bubbles.
REQ-020 out_row_last SHALL be 1 on the final set bit of the current row, and out_last SHALL be 1 on the nnz-th element.
REQ-021 done SHALL pulse for exactly the one DONE cycle; busy SHALL be 1 in every state except IDLE.
REQ-022 start SHALL be ignored when not in IDLE, and start in the DONE cycle SHALL be ignored.
REQ-023 An all-zero mask SHALL issue nothing: done follows the flag handshake by 1 cycle.
REQ-024 A full mask (nnz=KERNEL_SIZE) SHALL fill all entries with no pointer wrap-around.

Reset
REQ-025 Reset SHALL immediately force IDLE, clearing the mask, nnz, pointers and buffer.
REQ-026 All outputs SHALL read 0 during and after reset.
REQ-027 A reset mid-pass SHALL discard the pass; no done pulse is issued.

Configuration
REQ-028 With WEI_SCHED_EMPTY_ROW_EN defined, each row whose mask bits are all zero SHALL issue one marker element: out_data=0, out_row=r, out_col=0, out_row_last=1.
REQ-029 With WEI_SCHED_EMPTY_ROW_EN defined, out_last SHALL mark the final element issued, which may be a marker; an all-zero mask then issues KERNEL_WIDTH markers via LOAD->ISSUE with zero loads.
REQ-030 Without WEI_SCHED_EMPTY_ROW_EN, empty rows SHALL be skipped silently.

Structure
REQ-031 A shared package SHALL hold DATA_WIDTH, KERNEL_WIDTH, KERNEL_SIZE, the index widths and the FSM state enum.
REQ-032 Sub-module popcnt SHALL produce row counts and nnz, instanced once per row plus once for the full mask.

Verification
REQ-033 The bench SHALL cover: mask 9'b000_000_001, weight 0x5A, out_ready=1 -> one output (0x5A, row 0, col 0, row_last=1, last=1), done 2 cycles after the weight handshake.
REQ-034 The bench SHALL cover: mask 9'b101_010_101, weights 1..5 -> outputs (1,0,0),(2,0,2),(3,1,1),(4,2,0),(5,2,2); row_last on 2, 3 and 5; last on 5.
REQ-035 The bench SHALL cover: full mask, weights 0x10..0x18, out_ready toggling 1/0 -> 9 outputs in order, each stable while stalled, nnz=9.
REQ-036 The bench SHALL cover: mask 0 -> done 1 cycle after the flag handshake and no out_valid; with the macro defined, 3 markers (row 0, 1, 2) instead.
REQ-037 The bench SHALL cover: reset asserted mid-ISSUE after 2 of 4 outputs -> all outputs 0 immediately, busy=0, no done; a new start then runs normally.
REQ-038 The bench SHALL cover: start pulsed during LOAD -> ignored and the pass completes unchanged.
